// File: rtl/btn_charge_meter.sv
// btn_charge_meter
//   Conditions the raw player button and measures how long it is held.
//   The button is synchronised, debounced, and its hold time while the
//   downstream FSM is armed is turned into a squeeze level (0..14).
//   When the button is released, the block emits a one-cycle press pulse.
//   It also latches an initial jump velocity V_MIN + level*V_STEP,
//   saturated to 11 bits.
//
// Ports
//   clk_machine   in   system clock
//   rst_machine   in   synchronous active-high reset
//   i_btn         in   raw button (active high, asynchronous)
//   i_arm         in   FSM ready to accept a charge
//   o_btn_db      out  debounced button level
//   o_charging    out  high while charging
//   o_squeeze     out  squeeze level 0..14, 0 when not charging
//   o_v_init      out  velocity of the last completed press
//   o_press_valid out  one-cycle pulse; o_v_init is valid in the same cycle
module btn_charge_meter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 1600000,
  parameter int V_MIN           = 20,
  parameter int V_STEP          = 8
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic        i_btn,
  input  logic        i_arm,
  output logic        o_btn_db,
  output logic        o_charging,
  output logic [3:0]  o_squeeze,
  output logic [10:0] o_v_init,
  output logic        o_press_valid
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(STEP_CYCLES - 1);
  localparam logic [3:0]      LEVEL_MAX = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            sync1_r, sync2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            btn_db_r, prev_r;
  logic [ST_W-1:0] step_cnt_r, step_cnt_s;
  logic [3:0]      level_r, level_s;
  logic [10:0]     v_init_r, v_init_s;
  logic            press_valid_r, press_valid_s;
  logic            rise_s, fall_s;

  // Velocity for a given squeeze level; computed wide, then clamped to 2047.
  function automatic logic [10:0] calc_v(input logic [3:0] lvl);
    logic [31:0] sum;
    sum = 32'(V_MIN) + (32'(lvl) * 32'(V_STEP));
    if (sum > 32'd2047) begin
      calc_v = 11'd2047;
    end else begin
      calc_v = sum[10:0];
    end
  endfunction

  // Two-flop synchroniser plus debounce counter and previous-level register.
  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      db_cnt_r <= '0;
      btn_db_r <= 1'b0;
      prev_r   <= 1'b0;
    end else begin
      sync1_r <= i_btn;
      sync2_r <= sync1_r;
      prev_r  <= btn_db_r;
      if (sync2_r == btn_db_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        // The synchronised level has differed for DEBOUNCE_CYCLES edges.
        btn_db_r <= ~btn_db_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  // Next-state and charge datapath.
  always_comb begin
    rise_s        = btn_db_r & ~prev_r;
    fall_s        = ~btn_db_r & prev_r;
    state_s       = state_r;
    step_cnt_s    = step_cnt_r;
    level_s       = level_r;
    v_init_s      = v_init_r;
    press_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          if (i_arm) begin
            state_s    = ST_CHARGE;
            step_cnt_s = '0;
            level_s    = 4'd0;
          end else begin
            state_s = ST_BLOCKED;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHARGE: begin
        // Release wins over both a same-cycle step and an arm drop.
        if (fall_s) begin
          v_init_s      = calc_v(level_r);
          press_valid_s = 1'b1;
          state_s       = ST_IDLE;
          step_cnt_s    = '0;
          level_s       = 4'd0;
        end else if (!i_arm) begin
          state_s    = ST_BLOCKED;
          step_cnt_s = '0;
          level_s    = 4'd0;
        end else if (step_cnt_r == STEP_LAST) begin
          step_cnt_s = '0;
          if (level_r != LEVEL_MAX) begin
            level_s = level_r + 4'd1;
          end else begin
            level_s = level_r;
          end
        end else begin
          step_cnt_s = step_cnt_r + ST_W'(1);
        end
      end
      ST_BLOCKED: begin
        // Wait for a real release so a held button cannot auto-charge.
        if (!btn_db_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BLOCKED;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        step_cnt_s = '0;
        level_s    = 4'd0;
      end
    endcase
  end

  // State and charge registers.
  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      state_r       <= ST_IDLE;
      step_cnt_r    <= '0;
      level_r       <= 4'd0;
      v_init_r      <= 11'(V_MIN);
      press_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      step_cnt_r    <= step_cnt_s;
      level_r       <= level_s;
      v_init_r      <= v_init_s;
      press_valid_r <= press_valid_s;
    end
  end

  // level_r is cleared whenever CHARGE is left, so it drives o_squeeze directly.
  assign o_btn_db      = btn_db_r;
  assign o_charging    = (state_r == ST_CHARGE);
  assign o_squeeze     = level_r;
  assign o_v_init      = v_init_r;
  assign o_press_valid = press_valid_r;

endmodule

// File: tb/tb_btn_charge_meter.sv
module tb_btn_charge_meter;

  localparam int D    = 4;
  localparam int STEP = 8;
  localparam int VMIN = 20;
  localparam int VSTP = 8;

  logic        clk = 1'b0;
  logic        rst_machine = 1'b1;
  logic        i_btn = 1'b1;
  logic        i_arm = 1'b0;
  logic        o_btn_db, o_charging, o_press_valid;
  logic [3:0]  o_squeeze;
  logic [10:0] o_v_init;

  int n_cmp = 0;
  int n_bad = 0;

  btn_charge_meter #(
    .DEBOUNCE_CYCLES(D), .STEP_CYCLES(STEP), .V_MIN(VMIN), .V_STEP(VSTP)
  ) dut (
    .clk_machine(clk), .rst_machine(rst_machine), .i_btn(i_btn), .i_arm(i_arm),
    .o_btn_db(o_btn_db), .o_charging(o_charging), .o_squeeze(o_squeeze),
    .o_v_init(o_v_init), .o_press_valid(o_press_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level flips once the synchronised button (raw delayed by two
  // samples) has disagreed with it for D consecutive samples.
  // Squeeze level = elapsed charge cycles / STEP, capped at 14.
  int m_db, m_prev, m_mode, m_el, m_v, m_pv;  // mode: 0 idle, 1 charge, 2 blocked
  int hist [0:15];
  bit chk_en = 1'b0;

  function automatic int model_level();
    return (m_el / STEP > 14) ? 14 : m_el / STEP;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst_machine) begin
        m_db = 0; m_prev = 0; m_mode = 0; m_el = 0; m_v = VMIN; m_pv = 0;
        for (int k = 0; k < 16; k++) hist[k] = 0;
        chk_en = 1'b1;
      end else begin
        int rise, fall, tog, lvl;
        rise = (m_db == 1 && m_prev == 0) ? 1 : 0;
        fall = (m_db == 0 && m_prev == 1) ? 1 : 0;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(i_btn);
        tog = 1;
        for (int k = 2; k < 2 + D; k++) if (hist[k] == m_db) tog = 0;
        lvl = model_level();
        m_pv = 0;
        if (m_mode == 0) begin
          if (rise == 1) begin
            m_mode = i_arm ? 1 : 2;
            m_el = 0;
          end
        end else if (m_mode == 1) begin
          if (fall == 1) begin
            m_v = VMIN + lvl * VSTP;
            if (m_v > 2047) m_v = 2047;
            m_pv = 1; m_mode = 0; m_el = 0;
          end else if (!i_arm) begin
            m_mode = 2; m_el = 0;
          end else begin
            m_el++;
          end
        end else begin
          if (m_db == 0) m_mode = 0;
        end
        m_prev = m_db;
        if (tog == 1) m_db = 1 - m_db;
      end
      #1;
      if (chk_en) begin
        check("btn_db", int'(o_btn_db), m_db);
        check("charging", int'(o_charging), (m_mode == 1) ? 1 : 0);
        check("squeeze", int'(o_squeeze), (m_mode == 1) ? model_level() : 0);
        check("press_valid", int'(o_press_valid), m_pv);
        check("v_init", int'(o_v_init), m_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sq(input int tgt, input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (int'(o_squeeze) == tgt) begin ok = 1'b1; break; end
    end
    check("wait_squeeze", int'(ok), 1);
  endtask

  task automatic wait_pv(input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (o_press_valid) begin ok = 1'b1; break; end
    end
    check("wait_pulse", int'(ok), 1);
  endtask

  initial begin
    int lat, hi_cnt;
    // Reset held 3 cycles with the button pressed.
    tick(3);
    check("rst_btn_db", int'(o_btn_db), 0);
    check("rst_charging", int'(o_charging), 0);
    check("rst_squeeze", int'(o_squeeze), 0);
    check("rst_pv", int'(o_press_valid), 0);
    check("rst_v_init", int'(o_v_init), 20);
    rst_machine = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (o_btn_db) begin lat = k; break; end
    end
    check("rise_latency", lat, 6);
    @(negedge clk); i_btn = 1'b0;
    tick(12);

    // Normal press up to level 5.
    i_arm = 1'b1; i_btn = 1'b1;
    wait_sq(5, 200);
    @(negedge clk); i_btn = 1'b0;
    wait_pv(30);
    check("normal_v_init", int'(o_v_init), 60);
    @(posedge clk); #1;
    check("normal_squeeze_after", int'(o_squeeze), 0);
    tick(10);

    // Saturation.
    i_btn = 1'b1;
    tick(200);
    check("sat_squeeze", int'(o_squeeze), 14);
    i_btn = 1'b0;
    wait_pv(30);
    check("sat_v_init", int'(o_v_init), 132);
    tick(10);

    // Glitch rejection: 3 cycles rejected, 4 cycles accepted for 4 cycles.
    i_btn = 1'b1; tick(3); i_btn = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 15; k++) begin @(posedge clk); #1; if (o_btn_db) hi_cnt++; end
    check("glitch3_db_high", hi_cnt, 0);
    @(negedge clk); i_btn = 1'b1; tick(4); i_btn = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (o_btn_db) hi_cnt++; end
    check("glitch4_db_high", hi_cnt, 4);
    check("glitch4_v_init", int'(o_v_init), 20);
    tick(5);

    // Unarmed press, then arm while held.
    i_arm = 1'b0; i_btn = 1'b1;
    tick(12);
    check("unarmed_charging", int'(o_charging), 0);
    i_arm = 1'b1;
    tick(20);
    check("rearm_charging", int'(o_charging), 0);
    i_btn = 1'b0;
    tick(12);
    i_btn = 1'b1;
    wait_sq(2, 100);
    @(negedge clk); i_btn = 1'b0;
    wait_pv(30);
    check("after_block_v_init", int'(o_v_init), 36);
    tick(10);

    // Abort at level 3.
    i_btn = 1'b1;
    wait_sq(3, 100);
    @(negedge clk); i_arm = 1'b0;
    @(posedge clk); #1;
    check("abort_squeeze", int'(o_squeeze), 0);
    check("abort_charging", int'(o_charging), 0);
    check("abort_v_init", int'(o_v_init), 36);
    @(negedge clk); i_btn = 1'b0;
    tick(12);
    i_arm = 1'b1;

    // Reset mid-charge at level 6.
    i_btn = 1'b1;
    wait_sq(6, 150);
    @(negedge clk); rst_machine = 1'b1;
    @(posedge clk); #1;
    check("midrst_squeeze", int'(o_squeeze), 0);
    check("midrst_v_init", int'(o_v_init), 20);
    check("midrst_charging", int'(o_charging), 0);
    @(negedge clk); rst_machine = 1'b0;
    tick(2);
    i_btn = 1'b0;
    tick(15);

    // Randomised phase checked by the model every cycle.
    for (int it = 0; it < 150; it++) begin
      i_btn = ($urandom_range(0, 3) != 0) ? ~i_btn : i_btn;
      if ($urandom_range(0, 5) == 0) i_arm = ~i_arm;
      if ($urandom_range(0, 40) == 0) begin
        rst_machine = 1'b1; tick(1); rst_machine = 1'b0;
      end
      tick(($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 130));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_charge_meter.md
Name: btn_charge_meter

Overview:
- Upstream stage of wechat_jump_fsm: conditions the raw player button and measures press duration.
- Synchronises and debounces i_btn, then counts hold time into a squeeze level 0–14 while the FSM is armed.
- On release, emits a one-cycle press-valid pulse and a latched initial jump velocity in the same 11-bit format jump consumes.
- Replaces the FSM's direct use of the raw button.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a level change (~10 ms at 25.175 MHz).
- STEP_CYCLES, 1600000: hold cycles per squeeze-level increment.
- V_MIN, 20: o_v_init at level 0.
- V_STEP, 8: o_v_init increment per level.

Ports:
- clk_machine  input  1  system clock (25.175 MHz).
- rst_machine  input  1  reset; one clock; reset is synchronous and active-high.
- i_btn  input  1  raw button, active high, asynchronous to clock.
- i_arm  input  1  level from FSM: ready to accept a charge (waiting-for-press state).
- o_btn_db  output  1  debounced button level.
- o_charging  output  1  high while in CHARGE.
- o_squeeze  output  4  current squeeze level 0–14; 0 outside CHARGE.
- o_v_init  output  11  initial velocity of last completed press; held until next press.
- o_press_valid  output  1  one-cycle pulse; o_v_init is valid in the same cycle.

Behaviour:
- Reset values: o_btn_db=0, o_charging=0, o_squeeze=0, o_v_init=V_MIN, o_press_valid=0, state=IDLE; synchroniser flops, debounce counter and step counter all 0.
- Synchroniser: two flops, i_btn→s1→s2.
- Debounce:
  - Counter clears on any cycle where s2==o_btn_db.
  - Otherwise it increments. When it equals DEBOUNCE_CYCLES-1 and s2 still differs, o_btn_db toggles on the next edge and the counter clears.
  - Latency from a stable raw change to o_btn_db change is exactly 2+DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles (at s2) produce no change.
- Edges: rise = o_btn_db & ~prev; fall = ~o_btn_db & prev. The prev register resets to 0.
- IDLE:
  - rise & i_arm → CHARGE; level=0, step_cnt=0.
  - rise & ~i_arm → BLOCKED.
- CHARGE:
  - o_charging=1, o_squeeze=level.
  - step_cnt increments each cycle. At STEP_CYCLES-1 it wraps to 0 and level increments, saturating at 14; step_cnt keeps wrapping after saturation.
  - On fall, taking priority over a same-cycle step:
    - o_v_init <= V_MIN + level*V_STEP, using the level before any same-cycle increment.
    - Computed 12-bit and saturated to 2047.
    - o_press_valid=1 for that single cycle; go IDLE. o_squeeze and o_charging read 0 from the next cycle.
  - If i_arm drops while the button is still held (no fall): abort to BLOCKED with o_squeeze=0, no pulse, o_v_init unchanged.
  - If fall and i_arm drop occur in the same cycle, the fall wins: pulse is emitted, go IDLE.
- BLOCKED: ignore everything until o_btn_db==0, then go IDLE on the next edge. This prevents a held button from auto-charging when the FSM rearms.
- A button held through reset: o_btn_db starts at 0 and rises after debounce latency, which is treated as a fresh press.
- Reset asserted mid-CHARGE: all outputs return to reset values on that edge, with no pulse.
- o_press_valid never asserts in two consecutive cycles; at most one pulse per debounced press.

Test Plan:
Use DEBOUNCE_CYCLES=4, STEP_CYCLES=8, V_MIN=20, V_STEP=8.
- Reset/idle: hold rst_machine 3 cycles with i_btn=1 → all outputs at reset values. Release reset with i_btn=1 → o_btn_db rises exactly 6 cycles later.
- Normal press, i_arm=1: o_btn_db high for 40 cycles in CHARGE → o_squeeze steps 1..5 every 8 cycles. On fall, o_press_valid pulses once with o_v_init=60; o_squeeze=0 on the next cycle.
- Saturation: hold 200 cycles → o_squeeze stops at 14; release gives o_v_init=132.
- Glitch rejection: 3-cycle high pulse on i_btn → o_btn_db stays 0, no state change. 4-cycle pulse → o_btn_db high for exactly 4 cycles.
- Unarmed / abort cases:
  - Press with i_arm=0 → no charging, no pulse. Raise i_arm while held → still no pulse. Release, press again → normal charge.
  - Drop i_arm at level 3 → o_squeeze=0 next cycle, no pulse, o_v_init keeps its prior value.
- Reset mid-charge at level 6 → outputs reset on that edge. Fall of the same press after reset: o_btn_db is 0 after reset, so no pulse is produced.
